// File: rtl/rdrsp_buf_nr1wa_pkg.sv
// nr1wa_pkg: shared constants, pointer type and helpers for the nr1wa read front end.
package nr1wa_pkg;

    localparam int RD_LAT_DFLT = 3;

    // Wide enough for the deepest legal FIFO (16 entries).
    typedef logic [3:0] fifo_ptr_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/rdrsp_buf_nr1wa_if.sv
// rdrsp_buf_nr1wa_if: client-side request/response bundle for all read ports.
interface rdrsp_buf_nr1wa_if #(
    parameter int WIDTH   = 32,
    parameter int BITADDR = 13,
    parameter int NUMRDPT = 4
);

    logic [NUMRDPT-1:0]         cl_rd_vld;
    logic [NUMRDPT-1:0]         cl_rd_rdy;
    logic [NUMRDPT*BITADDR-1:0] cl_rd_adr;
    logic [NUMRDPT-1:0]         cl_rsp_vld;
    logic [NUMRDPT-1:0]         cl_rsp_rdy;
    logic [NUMRDPT*WIDTH-1:0]   cl_rsp_dout;

    modport master (
        output cl_rd_vld, cl_rd_adr, cl_rsp_rdy,
        input  cl_rd_rdy, cl_rsp_vld, cl_rsp_dout
    );

    modport slave (
        input  cl_rd_vld, cl_rd_adr, cl_rsp_rdy,
        output cl_rd_rdy, cl_rsp_vld, cl_rsp_dout
    );

endinterface

// File: rtl/rdrsp_buf_nr1wa_fifo.sv
// rdrsp_fifo: one port's response FIFO; head is driven straight from storage, overflowing pushes are dropped.
module rdrsp_fifo
    import nr1wa_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int FIFODEP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             ovf
);

    localparam int                BITCNT = clog2(FIFODEP + 1);
    localparam fifo_ptr_t         LAST   = fifo_ptr_t'(FIFODEP - 1);
    localparam logic [BITCNT-1:0] DEPC   = BITCNT'(FIFODEP);

    logic [WIDTH-1:0]  mem [16];
    fifo_ptr_t         wp, rp;
    logic [BITCNT-1:0] occ;
    logic              full, wr, rd;

    assign full  = occ == DEPC;
    assign empty = occ == '0;
    assign wr    = push & ~full;
    assign rd    = pop & ~empty;
    assign ovf   = push & full;
    assign dout  = mem[rp];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            occ <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            if (wr) begin
                mem[wp] <= din;
                wp      <= wp == LAST ? '0 : wp + 1'b1;
            end
            if (rd) rp <= rp == LAST ? '0 : rp + 1'b1;
            occ <= occ + BITCNT'(wr) - BITCNT'(rd);
        end
    end

endmodule

// File: rtl/rdrsp_buf_nr1wa.sv
// rdrsp_buf_nr1wa: credit-based valid/ready front end for the fixed-latency nr1wa read ports,
// with a per-port latency checker and sticky error flag.
module rdrsp_buf_nr1wa
    import nr1wa_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int BITADDR = 13,
    parameter int NUMRDPT = 4,
    parameter int RD_LAT  = RD_LAT_DFLT,
    parameter int FIFODEP = 4,
    parameter int BITFIFO = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    rdrsp_buf_nr1wa_if.slave           cl,
    output logic [NUMRDPT-1:0]         read,
    output logic [NUMRDPT*BITADDR-1:0] rd_adr,
    input  logic [NUMRDPT-1:0]         rd_vld,
    input  logic [NUMRDPT*WIDTH-1:0]   rd_dout,
    output logic [NUMRDPT-1:0]         err
);

    localparam logic [BITFIFO:0] DEPC = (BITFIFO + 1)'(FIFODEP);

    assign rd_adr = cl.cl_rd_adr;

    for (genvar p = 0; p < NUMRDPT; p++) begin : g_port
        logic [BITFIFO:0]  cnt;
        logic [RD_LAT-1:0] exp;
        logic              err_q, empty, ovf, pop;

        // Credits cover both in-flight core reads and held entries, so a push can never find the FIFO full.
        assign cl.cl_rd_rdy[p]  = cnt < DEPC;
        assign read[p]          = cl.cl_rd_vld[p] & cl.cl_rd_rdy[p];
        assign cl.cl_rsp_vld[p] = ~empty;
        assign pop              = ~empty & cl.cl_rsp_rdy[p];
        assign err[p]           = err_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt   <= '0;
                exp   <= '0;
                err_q <= 1'b0;
            end else begin
                cnt   <= cnt + (BITFIFO + 1)'(read[p]) - (BITFIFO + 1)'(pop);
                exp   <= RD_LAT'({exp, read[p]});
                err_q <= err_q | ovf | (rd_vld[p] != exp[RD_LAT-1]);
            end
        end

        rdrsp_fifo #(.WIDTH(WIDTH), .FIFODEP(FIFODEP)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (rd_vld[p]),
            .din   (rd_dout[p*WIDTH +: WIDTH]),
            .pop   (pop),
            .dout  (cl.cl_rsp_dout[p*WIDTH +: WIDTH]),
            .empty (empty),
            .ovf   (ovf)
        );
    end

endmodule
